img_grad_stream: RTL

//  Parametrised streaming forward-difference gradient engine for the image memory subsystem.
//  - Reads a WIDTH x HEIGHT 8-bit-class image once, in raster order, over the img_* port.
//  - Writes one packed {Gx,Gy} word per pixel over the grad_* port.
//  - Holds only a (WIDTH+1)-deep pixel delay line, never a full frame; adds start/busy control
//    and defined edge handling.

---
 rtl/img_pkg.sv | 19 +
 rtl/pix_delay_line.sv | 26 ++
 rtl/img_grad_stream.sv | 101 ++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared state encoding, default geometry and gradient word packing for img_grad_stream
package img_pkg;

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

    localparam int DEF_WIDTH  = 256;
    localparam int DEF_HEIGHT = 256;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_GRAD_W = 10;
    localparam int DEF_ADDR_W = 16;

    // Packs two w-bit two's complement components as {gx, gy}; callers truncate to 2*w bits
    function automatic logic [63:0] pack_grad(input logic [31:0] gx, input logic [31:0] gy, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (({32'd0, gx} & m) << w) | ({32'd0, gy} & m);
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// pix_delay_line: DEPTH-tap pixel shift line whose newest tap is the live input
module pix_delay_line import img_pkg::*; #(
    parameter int DEPTH = DEF_WIDTH + 1,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap_old,
    output logic [PIX_W-1:0] tap_next,
    output logic [PIX_W-1:0] tap_new
);

    logic [(DEPTH-1)*PIX_W-1:0] line;

    // Stores the DEPTH-1 samples preceding din, newest in the low slot
    always_ff @(posedge clk)
        if (reset) line <= '0;
        else if (shift) line <= {line[(DEPTH-2)*PIX_W-1:0], din};

    assign tap_old  = line[(DEPTH-1)*PIX_W-1 -: PIX_W];
    assign tap_next = line[(DEPTH-2)*PIX_W-1 -: PIX_W];
    assign tap_new  = din;

endmodule

// File: rtl/img_grad_stream.sv
// img_grad_stream: streaming forward-difference {Gx,Gy} engine over a raster-read image
module img_grad_stream import img_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int GRAD_W = DEF_GRAD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                img_rd,
    output logic [ADDR_W-1:0]   img_addr,
    input  logic [PIX_W-1:0]    img_di,
    output logic                grad_wr,
    output logic [ADDR_W-1:0]   grad_addr,
    output logic [2*GRAD_W-1:0] grad_do
);

    localparam logic [ADDR_W:0]   N        = (ADDR_W+1)'(WIDTH * HEIGHT);
    localparam logic [ADDR_W:0]   N_LAST   = (ADDR_W+1)'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W:0]   FILL_END = (ADDR_W+1)'(WIDTH + 1);
    localparam logic [ADDR_W-1:0] X_END    = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_END    = ADDR_W'(HEIGHT - 1);

    state_t state, state_nx;
    logic [ADDR_W:0] rd_cnt, wr_cnt;
    logic [ADDR_W-1:0] x, y;
    logic go, calc;
    logic [PIX_W-1:0] pix, pix_right, pix_below;
    logic [GRAD_W-1:0] gx, gy;

    // State register
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

    // Next state and control; calc marks the cycle whose img_di completes a pixel's neighbourhood
    always_comb begin
        go = start && (state == IDLE || state == DONE);
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? FILL : IDLE;
            FILL:    state_nx = rd_cnt == FILL_END ? RUN : FILL;
            RUN:     state_nx = rd_cnt >= N_LAST ? DRAIN : RUN;
            DRAIN:   state_nx = wr_cnt == N ? DONE : DRAIN;
            DONE:    state_nx = go ? FILL : IDLE;
            default: state_nx = IDLE;
        endcase
        busy = state == FILL || state == RUN || state == DRAIN;
        done = state == DONE;
        img_rd = (state == FILL || state == RUN) && rd_cnt != N;
        calc = (state == FILL && rd_cnt == FILL_END) || ((state == RUN || state == DRAIN) && wr_cnt != N);
    end

    assign img_addr = rd_cnt[ADDR_W-1:0];

    // Read counter, write counter and the x/y position of the pixel being computed
    always_ff @(posedge clk)
        if (reset || go) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            x <= '0;
            y <= '0;
        end else begin
            if (img_rd) rd_cnt <= rd_cnt + 1'b1;
            if (calc) begin
                wr_cnt <= wr_cnt + 1'b1;
                x <= x == X_END ? '0 : x + 1'b1;
                y <= x == X_END ? y + 1'b1 : y;
            end
        end

    pix_delay_line #(.DEPTH(WIDTH + 1), .PIX_W(PIX_W)) u_line (
        .clk      (clk),
        .reset    (reset),
        .shift    (busy),
        .din      (img_di),
        .tap_old  (pix),
        .tap_next (pix_right),
        .tap_new  (pix_below)
    );

    assign gx = x == X_END ? '0 : GRAD_W'(pix_right) - GRAD_W'(pix);
    assign gy = y == Y_END ? '0 : GRAD_W'(pix_below) - GRAD_W'(pix);

    // Registered write port; address and data hold between writes
    always_ff @(posedge clk)
        if (reset) begin
            grad_wr <= 1'b0;
            grad_addr <= '0;
            grad_do <= '0;
        end else begin
            grad_wr <= calc;
            if (calc) begin
                grad_addr <= wr_cnt[ADDR_W-1:0];
                grad_do <= (2*GRAD_W)'(pack_grad(32'(gx), 32'(gy), GRAD_W));
            end
        end

endmodule
